fft_butterfly_pipe: RTL and testbench
=====================================

Name: fft_butterfly_pipe

Overview:
Pipelined radix-2 decimation-in-time butterfly for the 32-point FFT datapath. It drives the twiddle index (tw_select) and consumes the Q1.8 twiddle values returned combinationally by the real and imaginary twiddle multiplexers. It computes A' = A + B·W and B' = A − B·W.
Upstream and downstream connect through valid/ready handshakes. The FFT stage controller feeds the inputs, and the sample buffer writeback takes the outputs.

Parameters:
DATA_W, 16, signed width of each input real/imag component
TW_W, 9, signed twiddle width (Q1.8; +256 represents 1.0)
TW_FRAC, 8, twiddle fractional bits (rounding shift amount)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operands valid
in_ready  output  1  block accepts operands this cycle
in_a_re, in_a_im, in_b_re, in_b_im  input  DATA_W each  signed operands A, B
in_k  input  5  twiddle index 0..31
tw_select  output  6  twiddle mux select
tw_re, tw_im  input  TW_W each  signed twiddle, combinational return for tw_select
out_valid  output  1  results valid
out_ready  input  1  downstream accepts results
out_a_re, out_a_im, out_b_re, out_b_im  output  DATA_W+2 each  signed results A', B'

Behaviour:
- Decided: single clock clk; rst_n asynchronous, active-low.
- Pipeline structure: three register stages S0, S1, S2, each with its own valid bit.
  - Global stall: adv = !out_valid | out_ready. All stages advance only when adv = 1.
  - in_ready = adv, combinational. Bubbles are not collapsed.
- S0 (accept): on in_valid & adv, register A, B and k. tw_select = {1'b0, k_s0}, driven from the S0 register, never directly from in_k.
- S1: register four signed products of width DATA_W+TW_W:
  - b_re·tw_re
  - b_im·tw_im
  - b_re·tw_im
  - b_im·tw_re
  - A is carried forward unchanged.
- S2 arithmetic:
  - t_re = (b_re·w_re − b_im·w_im + 2^(TW_FRAC−1)) >>> TW_FRAC
  - t_im = (b_re·w_im + b_im·w_re + 2^(TW_FRAC−1)) >>> TW_FRAC
  - Rounding is round-half-up via arithmetic shift. Sums use full width: no truncation before the shift.
  - t is held at DATA_W+2 bits.
  - out_a = a + t and out_b = a − t, with a sign-extended to DATA_W+2. No saturation; the result range is provably within DATA_W+2.
- Latency: exactly 3 cycles from an accepted input to out_valid, when out_ready is held high. Throughput is 1 per cycle.
- Stall: while out_valid & !out_ready:
  - in_ready = 0
  - all stage registers and outputs hold
  - tw_select holds
- Reset values: all valid bits 0; out_valid 0; all out_* data 0; tw_select 0; in_ready 1 after reset.
- Reset mid-operation: in-flight operands are discarded, with no partial output. The first accept after release produces the first result.
- Simultaneous accept and output drain: allowed in the same cycle whenever out_ready = 1.
- Output stability: output data must remain stable while out_valid & !out_ready.

Optional Feature:
BFLY_SCALE_EN:
- Defined: both S2 results are scaled by 1/2 per stage, computed as (x + 1) >>> 1 (round-half-up). The result is sign-extended to DATA_W+2; the value fits in DATA_W+1. Latency is unchanged.
- Undefined: no scaling; outputs are the unscaled sums/differences.

Test Plan:
1. k=0 (W=256+0j), a=(100,0), b=(50,0) -> after 3 cycles out_a=(150,0), out_b=(50,0); tw_select=0 while in S0.
2. k=16 (W=0−256j), a=(100,0), b=(50,20) -> out_a=(120,−50), out_b=(80,50); tw_select=6'd16.
3. k=8 (W=181−181j):
   - a=(0,0), b=(256,0) -> out_a=(181,−181), out_b=(−181,181).
   - b=(1,0) -> out_a=(1,−1) (rounding check).
4. Extremes: k=8, a=(−32768,0), b=(−32768,−32768) -> out_a=(−79104,0), out_b=(13568,0); no wrap at DATA_W+2.
5. Back-to-back stream of 8 ops with out_ready low for cycles 4–6 -> in_ready low exactly while out_valid & !out_ready; all 8 results emitted in order, none lost or duplicated. Assert rst_n mid-stream -> out_valid 0 immediately, tw_select 0.
6. With BFLY_SCALE_EN: scenario 1 -> out_a=(75,0), out_b=(25,0); a=(101,0), b=(50,0), k=0 -> out_a=(76,0).

Source files
------------

// File: rtl/fft_butterfly_pipe_if.sv
// ============================================================================
// Module   : fft_butterfly_pipe_if
// Brief    : Operand/result handshakes and twiddle lookup for the butterfly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_butterfly_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 9
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a_re;
    logic signed [DATA_W-1:0] in_a_im;
    logic signed [DATA_W-1:0] in_b_re;
    logic signed [DATA_W-1:0] in_b_im;
    logic        [4:0]        in_k;
    logic        [5:0]        tw_select;
    logic signed [TW_W-1:0]   tw_re;
    logic signed [TW_W-1:0]   tw_im;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W+1:0] out_a_re;
    logic signed [DATA_W+1:0] out_a_im;
    logic signed [DATA_W+1:0] out_b_re;
    logic signed [DATA_W+1:0] out_b_im;

    modport slave (
        input  in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k,
        input  tw_re, tw_im, out_ready,
        output in_ready, tw_select,
        output out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );

    modport master (
        output in_valid, in_a_re, in_a_im, in_b_re, in_b_im, in_k,
        output tw_re, tw_im, out_ready,
        input  in_ready, tw_select,
        input  out_valid, out_a_re, out_a_im, out_b_re, out_b_im
    );
endinterface

`default_nettype wire

// File: rtl/fft_butterfly_pipe.sv
// ============================================================================
// Module   : fft_butterfly_pipe
// Brief    : 3-stage radix-2 DIT butterfly, A' = A + B*W, B' = A - B*W.
//            Define BFLY_SCALE_EN to halve both results (round-half-up).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_butterfly_pipe #(
    parameter int DATA_W  = 16,
    parameter int TW_W    = 9,
    parameter int TW_FRAC = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    fft_butterfly_pipe_if.slave   bus
);
    localparam int PROD_W = DATA_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int OUT_W  = DATA_W + 2;
    localparam logic signed [SUM_W-1:0] c_rnd = SUM_W'(1) <<< (TW_FRAC - 1);

    function automatic logic signed [OUT_W-1:0] f_scale(input logic signed [OUT_W-1:0] x);
`ifdef BFLY_SCALE_EN
        logic signed [OUT_W:0] w_tmp;
        w_tmp = (OUT_W+1)'(x) + (OUT_W+1)'(1);
        return OUT_W'(w_tmp >>> 1);
`else
        return x;
`endif
    endfunction

    // S0
    logic                     v0_q;
    logic signed [DATA_W-1:0] a_re_s0_q, a_im_s0_q, b_re_s0_q, b_im_s0_q;
    logic        [4:0]        k_s0_q;
    // S1
    logic                     v1_q;
    logic signed [DATA_W-1:0] a_re_s1_q, a_im_s1_q;
    logic signed [PROD_W-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    // S2 (output registers)
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_a_re_q, out_a_im_q, out_b_re_q, out_b_im_q;
    logic signed [OUT_W-1:0]  out_a_re_d, out_a_im_d, out_b_re_d, out_b_im_d;

    logic                     w_adv;
    logic signed [SUM_W-1:0]  w_sum_re, w_sum_im;
    logic signed [OUT_W-1:0]  w_t_re, w_t_im, w_a_re, w_a_im;

    assign w_adv         = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = w_adv;
    // Twiddle mux is combinational, so products are formed the cycle after accept.
    assign bus.tw_select = {1'b0, k_s0_q};
    assign bus.out_valid = out_valid_q;
    assign bus.out_a_re  = out_a_re_q;
    assign bus.out_a_im  = out_a_im_q;
    assign bus.out_b_re  = out_b_re_q;
    assign bus.out_b_im  = out_b_im_q;

    always_comb begin
        w_sum_re   = SUM_W'(p_rr_q) - SUM_W'(p_ii_q) + c_rnd;
        w_sum_im   = SUM_W'(p_ri_q) + SUM_W'(p_ir_q) + c_rnd;
        w_t_re     = OUT_W'(w_sum_re >>> TW_FRAC);
        w_t_im     = OUT_W'(w_sum_im >>> TW_FRAC);
        w_a_re     = OUT_W'(a_re_s1_q);
        w_a_im     = OUT_W'(a_im_s1_q);
        out_a_re_d = f_scale(w_a_re + w_t_re);
        out_a_im_d = f_scale(w_a_im + w_t_im);
        out_b_re_d = f_scale(w_a_re - w_t_re);
        out_b_im_d = f_scale(w_a_im - w_t_im);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q        <= 1'b0;
            a_re_s0_q   <= '0;
            a_im_s0_q   <= '0;
            b_re_s0_q   <= '0;
            b_im_s0_q   <= '0;
            k_s0_q      <= '0;
            v1_q        <= 1'b0;
            a_re_s1_q   <= '0;
            a_im_s1_q   <= '0;
            p_rr_q      <= '0;
            p_ii_q      <= '0;
            p_ri_q      <= '0;
            p_ir_q      <= '0;
            out_valid_q <= 1'b0;
            out_a_re_q  <= '0;
            out_a_im_q  <= '0;
            out_b_re_q  <= '0;
            out_b_im_q  <= '0;
        end else if (w_adv) begin
            v0_q <= bus.in_valid;
            if (bus.in_valid) begin
                a_re_s0_q <= bus.in_a_re;
                a_im_s0_q <= bus.in_a_im;
                b_re_s0_q <= bus.in_b_re;
                b_im_s0_q <= bus.in_b_im;
                k_s0_q    <= bus.in_k;
            end
            v1_q <= v0_q;
            if (v0_q) begin
                a_re_s1_q <= a_re_s0_q;
                a_im_s1_q <= a_im_s0_q;
                p_rr_q    <= PROD_W'(b_re_s0_q) * PROD_W'(bus.tw_re);
                p_ii_q    <= PROD_W'(b_im_s0_q) * PROD_W'(bus.tw_im);
                p_ri_q    <= PROD_W'(b_re_s0_q) * PROD_W'(bus.tw_im);
                p_ir_q    <= PROD_W'(b_im_s0_q) * PROD_W'(bus.tw_re);
            end
            out_valid_q <= v1_q;
            if (v1_q) begin
                out_a_re_q <= out_a_re_d;
                out_a_im_q <= out_a_im_d;
                out_b_re_q <= out_b_re_d;
                out_b_im_q <= out_b_im_d;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fft_butterfly_pipe.sv
// ============================================================================
// Module   : tb_fft_butterfly_pipe
// Brief    : Self-checking bench for fft_butterfly_pipe with a twiddle ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_butterfly_pipe;
`ifdef BFLY_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_butterfly_pipe_if #(.DATA_W(16), .TW_W(9)) bus ();

    fft_butterfly_pipe #(.DATA_W(16), .TW_W(9), .TW_FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 64-entry twiddle ROM, W = exp(-j*pi*sel/32) in Q1.8, +1.0 clamped to 255
    function automatic int qcos(input int i);
        int q[17];
        q = '{256, 255, 251, 245, 237, 226, 213, 198, 181, 162, 142, 121, 98, 74, 50, 25, 0};
        return q[i];
    endfunction
    function automatic int clamp9(input int v);
        return (v > 255) ? 255 : ((v < -256) ? -256 : v);
    endfunction
    function automatic int tw_re_of(input int k);
        return clamp9((k <= 16) ? qcos(k) : -qcos(32 - k));
    endfunction
    function automatic int tw_im_of(input int k);
        return clamp9((k <= 16) ? -qcos(16 - k) : -qcos(k - 16));
    endfunction

    assign bus.tw_re = 9'(tw_re_of(int'(bus.tw_select[4:0])));
    assign bus.tw_im = 9'(tw_im_of(int'(bus.tw_select[4:0])));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint post(input longint x);
        return SCALE ? fdiv(x + 1, 2) : x;
    endfunction

    function automatic longint sel(input longint unscaled, input longint scaled);
        return SCALE ? scaled : unscaled;
    endfunction

    typedef struct {
        longint ar, ai, br, bi;
        int     acc;
        bit     lat;
    } exp_t;
    exp_t exp_q[$];

    // Complex arithmetic reference: t = round_half_up(B*W / 256)
    function automatic exp_t model(input int are, input int aim, input int bre, input int bim, input int k);
        exp_t   e;
        longint wr, wi, tr, ti;
        wr = tw_re_of(k);
        wi = tw_im_of(k);
        tr = fdiv(longint'(bre) * wr - longint'(bim) * wi + 128, 256);
        ti = fdiv(longint'(bre) * wi + longint'(bim) * wr + 128, 256);
        e.ar = post(are + tr);
        e.ai = post(aim + ti);
        e.br = post(are - tr);
        e.bi = post(aim - ti);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    int  cyc = 0;
    bit  acc_prev = 1'b0;
    bit  stall_prev = 1'b0;
    int  acc_k = 0;
    logic signed [17:0] h_ar, h_ai, h_br, h_bi;
    logic [5:0]         h_tw;

    task automatic step(input bit v, input int are, input int aim, input int bre, input int bim,
                        input int k, input bit ordy, input bit lat);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a_re   = 16'(are);
        bus.in_a_im   = 16'(aim);
        bus.in_b_re   = 16'(bre);
        bus.in_b_im   = 16'(bim);
        bus.in_k      = 5'(k);
        bus.out_ready = ordy;
        #1;
        if (stall_prev) begin
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_hold_a_re", bus.out_a_re, h_ar);
            chk("stall_hold_a_im", bus.out_a_im, h_ai);
            chk("stall_hold_b_re", bus.out_b_re, h_br);
            chk("stall_hold_b_im", bus.out_b_im, h_bi);
            chk("stall_hold_tw", bus.tw_select, h_tw);
        end
        if (acc_prev) chk("tw_select", bus.tw_select, acc_k);
        chk("in_ready", bus.in_ready, !(bus.out_valid && !ordy));
        if (bus.out_valid && ordy) begin
            chk("spurious_out", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_a_re", bus.out_a_re, e.ar);
                chk("out_a_im", bus.out_a_im, e.ai);
                chk("out_b_re", bus.out_b_re, e.br);
                chk("out_b_im", bus.out_b_im, e.bi);
                if (e.lat) chk("latency", cyc - e.acc, 3);
            end
        end
        acc_prev = v && bus.in_ready;
        if (acc_prev) begin
            e = model(are, aim, bre, bim, k);
            e.acc = cyc;
            e.lat = lat;
            exp_q.push_back(e);
            acc_k = k;
        end
        stall_prev = bus.out_valid && !ordy;
        h_ar = bus.out_a_re;
        h_ai = bus.out_a_im;
        h_br = bus.out_b_re;
        h_bi = bus.out_b_im;
        h_tw = bus.tw_select;
        cyc++;
    endtask

    // One operation with out_ready high: result appears on the third idle step
    task automatic run_one(input int are, input int aim, input int bre, input int bim, input int k);
        step(1'b1, are, aim, bre, bim, k, 1'b1, 1'b1);
        repeat (3) step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("single_drained", exp_q.size(), 0);
    endtask

    function automatic int rnd16();
        return int'($signed(16'($urandom)));
    endfunction

    int sa_re[8], sa_im[8], sb_re[8], sb_im[8], sk[8];
    int idx;
    int guard;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a_re   = '0;
        bus.in_a_im   = '0;
        bus.in_b_re   = '0;
        bus.in_b_im   = '0;
        bus.in_k      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_tw_select", bus.tw_select, 0);
        chk("rst_out_a_re", bus.out_a_re, 0);
        chk("rst_out_b_im", bus.out_b_im, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // W = 1
        run_one(100, 0, 50, 0, 0);
        chk("t1_a_re", bus.out_a_re, sel(150, 75));
        chk("t1_a_im", bus.out_a_im, 0);
        chk("t1_b_re", bus.out_b_re, sel(50, 25));
        // W = -j
        run_one(100, 0, 50, 20, 16);
        chk("t2_a_re", bus.out_a_re, sel(120, 60));
        chk("t2_a_im", bus.out_a_im, sel(-50, -25));
        chk("t2_b_re", bus.out_b_re, sel(80, 40));
        chk("t2_b_im", bus.out_b_im, sel(50, 25));
        // W = (1-j)/sqrt2
        run_one(0, 0, 256, 0, 8);
        chk("t3_a_re", bus.out_a_re, sel(181, 91));
        chk("t3_a_im", bus.out_a_im, sel(-181, -90));
        chk("t3_b_re", bus.out_b_re, sel(-181, -90));
        chk("t3_b_im", bus.out_b_im, sel(181, 91));
        run_one(0, 0, 1, 0, 8);
        chk("t3r_a_re", bus.out_a_re, sel(1, 1));
        chk("t3r_a_im", bus.out_a_im, sel(-1, 0));
        // Extremes must not wrap
        run_one(-32768, 0, -32768, -32768, 8);
        chk("t4_a_re", bus.out_a_re, sel(-79104, -39552));
        chk("t4_a_im", bus.out_a_im, 0);
        chk("t4_b_re", bus.out_b_re, sel(13568, 6784));
        chk("t4_b_im", bus.out_b_im, 0);
        run_one(101, 0, 50, 0, 0);
        chk("t6_a_re", bus.out_a_re, sel(151, 76));

        // 8 back-to-back ops, downstream stalls on stream cycles 4..6
        for (int i = 0; i < 8; i++) begin
            sa_re[i] = rnd16(); sa_im[i] = rnd16();
            sb_re[i] = rnd16(); sb_im[i] = rnd16();
            sk[i]    = int'($urandom_range(0, 31));
        end
        idx = 0;
        guard = 0;
        while ((idx < 8 || exp_q.size() > 0) && guard < 40) begin
            if (idx < 8)
                step(1'b1, sa_re[idx], sa_im[idx], sb_re[idx], sb_im[idx], sk[idx],
                     !(guard >= 4 && guard <= 6), 1'b0);
            else
                step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            if (acc_prev) idx++;
            guard++;
        end
        chk("stream_all_accepted", idx, 8);
        chk("stream_drained", exp_q.size(), 0);

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++)
            step(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), int'($urandom_range(1, 31)), 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_tw_select", bus.tw_select, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_a_re", bus.out_a_re, 0);
        exp_q.delete();
        acc_prev   = 1'b0;
        stall_prev = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one(-5, 7, 300, -200, 5);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, rnd16(), rnd16(), rnd16(), rnd16(),
                 int'($urandom_range(0, 31)), ($urandom % 4) != 0, 1'b0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
            guard++;
        end
        chk("random_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
